// File: rtl/game_step_scheduler.sv
// Frame-pacing scheduler: turns frame_tick pulses into STEP_CYCLES-long step_en bursts for the Pong controller.
// Latency: first step_en clock follows the qualifying frame_tick by 1 clk; btn_raw reaches the FSM after 2 sync flops (+ debounce).
// Backpressure: none; ticks during a burst are dropped and flagged in sticky frame_overrun.
//
// Ports: clk/reset (sync, active-high); frame_tick, btn_raw, player_scored, ai_scored, game_over in;
//        step_en, paused, serving, halted, frame_overrun out.
// Optional feature: define SCHED_DEBOUNCE_EN to debounce the synchronised button over DEBOUNCE_CYCLES samples.
module game_step_scheduler #(
    parameter int STEP_CYCLES     = 4,
    parameter int FRAME_DIV       = 1,
    parameter int SERVE_FRAMES    = 60,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    input  logic btn_raw,
    input  logic player_scored,
    input  logic ai_scored,
    input  logic game_over,
    output logic step_en,
    output logic paused,
    output logic serving,
    output logic halted,
    output logic frame_overrun
);

    localparam int DIV_W   = $clog2(FRAME_DIV + 1);
    localparam int STEP_W  = $clog2(STEP_CYCLES + 1);
    localparam int SERVE_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(FRAME_DIV - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEP_CYCLES - 1);
    localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_FRAMES - 1);

    typedef enum logic [2:0] {
        WAIT_FRAME = 3'd0,
        RUN        = 3'd1,
        SERVE_WAIT = 3'd2,
        PAUSED     = 3'd3,
        OVER       = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [DIV_W-1:0]   div_cnt_q,   div_cnt_d;
    logic [STEP_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [SERVE_W-1:0] serve_cnt_q, serve_cnt_d;
    logic score_pend_q, score_pend_d;
    logic over_pend_q,  over_pend_d;
    logic pause_pend_q, pause_pend_d;
    logic overrun_q,    overrun_d;

    // Button path: 2-flop synchroniser, optional debounce, rising-edge detect.
    logic sync1_q, sync2_q;
    logic btn_prev_q;
    logic btn_lvl;
    logic btn_evt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            btn_prev_q <= btn_lvl;
        end
    end

`ifdef SCHED_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            db_lvl_q, db_lvl_d;

    // db_cnt counts consecutive samples that differ from the accepted level;
    // any sample matching the accepted level (i.e. a glitch back) restarts it.
    always_comb begin
        db_cnt_d = db_cnt_q;
        db_lvl_d = db_lvl_q;
        if (sync2_q == db_lvl_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q >= DB_LAST) begin
            db_lvl_d = sync2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt_q <= '0;
            db_lvl_q <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            db_lvl_q <= db_lvl_d;
        end
    end

    assign btn_lvl = db_lvl_q;
`else
    assign btn_lvl = sync2_q;
`endif

    assign btn_evt = btn_lvl & ~btn_prev_q;

    // Pend flags as they will stand after this burst clock, so flags raised
    // on the final burst clock still steer the exit.
    logic score_next, over_next;

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        serve_cnt_d  = serve_cnt_q;
        score_pend_d = score_pend_q;
        over_pend_d  = over_pend_q;
        pause_pend_d = pause_pend_q;
        overrun_d    = overrun_q;
        score_next   = score_pend_q | player_scored | ai_scored;
        over_next    = over_pend_q | game_over;

        case (state_q)
            WAIT_FRAME: begin
                // Pause wins over a same-cycle frame tick.
                if (btn_evt || pause_pend_q) begin
                    state_d      = PAUSED;
                    pause_pend_d = 1'b0;
                end else if (frame_tick) begin
                    if (div_cnt_q >= DIV_LAST) begin
                        div_cnt_d   = '0;
                        burst_cnt_d = '0;
                        state_d     = RUN;
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_W'(1);
                    end
                end
            end

            RUN: begin
                if (btn_evt) begin
                    pause_pend_d = 1'b1;
                end
                if (frame_tick) begin
                    overrun_d = 1'b1;
                end
                if (burst_cnt_q >= STEP_LAST) begin
                    burst_cnt_d  = '0;
                    score_pend_d = 1'b0;
                    over_pend_d  = 1'b0;
                    if (over_next) begin
                        state_d = OVER;
                    end else if (score_next) begin
                        serve_cnt_d = '0;
                        state_d     = SERVE_WAIT;
                    end else begin
                        state_d = WAIT_FRAME;
                    end
                end else begin
                    burst_cnt_d  = burst_cnt_q + STEP_W'(1);
                    score_pend_d = score_next;
                    over_pend_d  = over_next;
                end
            end

            SERVE_WAIT: begin
                // A press here is remembered and acted on from WAIT_FRAME.
                if (btn_evt) begin
                    pause_pend_d = 1'b1;
                end
                if (frame_tick) begin
                    if (serve_cnt_q >= SERVE_LAST) begin
                        serve_cnt_d = '0;
                        div_cnt_d   = '0;
                        state_d     = WAIT_FRAME;
                    end else begin
                        serve_cnt_d = serve_cnt_q + SERVE_W'(1);
                    end
                end
            end

            PAUSED: begin
                if (btn_evt) begin
                    div_cnt_d = '0;
                    state_d   = WAIT_FRAME;
                end
            end

            OVER: begin
                if (btn_evt) begin
                    div_cnt_d    = '0;
                    pause_pend_d = 1'b0;
                    state_d      = WAIT_FRAME;
                end
            end

            default: begin
                state_d = WAIT_FRAME;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_FRAME;
            div_cnt_q    <= '0;
            burst_cnt_q  <= '0;
            serve_cnt_q  <= '0;
            score_pend_q <= 1'b0;
            over_pend_q  <= 1'b0;
            pause_pend_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            serve_cnt_q  <= serve_cnt_d;
            score_pend_q <= score_pend_d;
            over_pend_q  <= over_pend_d;
            pause_pend_q <= pause_pend_d;
            overrun_q    <= overrun_d;
        end
    end

    // Outputs are gated by reset so a mid-burst reset kills step_en in the
    // very clock it is sampled, not one clock later.
    assign step_en       = ~reset & (state_q == RUN);
    assign paused        = ~reset & (state_q == PAUSED);
    assign serving       = ~reset & (state_q == SERVE_WAIT);
    assign halted        = ~reset & (state_q == OVER);
    assign frame_overrun = ~reset & overrun_q;

endmodule

// File: tb/tb_game_step_scheduler.sv
module tb_game_step_scheduler;

    logic clk = 1'b0;
    logic reset;
    logic frame_tick;
    logic btn_raw;
    logic player_scored;
    logic ai_scored;
    logic game_over;
    logic step_en;
    logic paused;
    logic serving;
    logic halted;
    logic frame_overrun;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    typedef struct {
        int start;
        int len;
    } burst_t;

    burst_t exp_q[$];

    game_step_scheduler #(
        .STEP_CYCLES    (4),
        .FRAME_DIV      (2),
        .SERVE_FRAMES   (3),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .btn_raw      (btn_raw),
        .player_scored(player_scored),
        .ai_scored    (ai_scored),
        .game_over    (game_over),
        .step_en      (step_en),
        .paused       (paused),
        .serving      (serving),
        .halted       (halted),
        .frame_overrun(frame_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Burst monitor: measures every step_en burst and matches it against the
    // scoreboard entry pushed when the qualifying tick was driven.
    logic mon_prev  = 1'b0;
    int   mon_start = 0;
    int   mon_len   = 0;

    always @(negedge clk) begin
        if (step_en === 1'b1) begin
            if (!mon_prev) begin
                mon_start = cyc;
                mon_len   = 0;
            end
            mon_len  = mon_len + 1;
            mon_prev = 1'b1;
        end else begin
            if (mon_prev) begin
                total = total + 1;
                if (exp_q.size() == 0) begin
                    $display("FAIL burst_unexpected: got start=%0d len=%0d, required no burst", mon_start, mon_len);
                end else begin
                    burst_t e;
                    e = exp_q.pop_front();
                    if (mon_start !== e.start || mon_len !== e.len)
                        $display("FAIL burst_shape: got start=%0d len=%0d, required start=%0d len=%0d",
                                 mon_start, mon_len, e.start, e.len);
                    else
                        passed = passed + 1;
                end
            end
            mon_prev = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    // All tasks are entered and left at #1 after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse frame_tick for one clock; blen>0 means this tick should launch a
    // burst of blen clocks starting the following clock.
    task automatic tick(input int blen);
        if (blen > 0) exp_q.push_back('{start: cyc + 1, len: blen});
        frame_tick = 1'b1;
        idle(1);
        frame_tick = 1'b0;
    endtask

    task automatic press();
`ifdef SCHED_DEBOUNCE_EN
        btn_raw = 1'b1;
        idle(14);
`else
        btn_raw = 1'b1;
        idle(3);
`endif
        btn_raw = 1'b0;
        idle(14);
    endtask

    task automatic check_drained(input string name);
        idle(8);
        total = total + 1;
        if (exp_q.size() != 0)
            $display("FAIL %s_drained: %0d bursts still expected, required 0", name, exp_q.size());
        else
            passed = passed + 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        frame_tick = 1'b0;
        btn_raw = 1'b0;
        player_scored = 1'b0;
        ai_scored = 1'b0;
        game_over = 1'b0;
        idle(3);
        total = total + 1;
        if ({step_en, paused, serving, halted, frame_overrun} !== 5'b0)
            $display("FAIL reset_outputs: got %b, required 00000",
                     {step_en, paused, serving, halted, frame_overrun});
        else
            passed = passed + 1;
        reset = 1'b0;
        idle(3);
        total = total + 1;
        if ({step_en, paused, serving, halted, frame_overrun} !== 5'b0)
            $display("FAIL post_reset_idle: got %b, required 00000",
                     {step_en, paused, serving, halted, frame_overrun});
        else
            passed = passed + 1;
    endtask

    task automatic test_bursts();
        for (int i = 0; i < 4; i++) begin
            tick((i % 2 == 1) ? 4 : 0);
            idle(7);
        end
        check_drained("bursts");
    endtask

    task automatic test_score();
        tick(0);
        idle(7);
        tick(4);
        idle(1);
        player_scored = 1'b1;
        idle(1);
        player_scored = 1'b0;
        idle(6);
        total = total + 1;
        if (serving !== 1'b1) $display("FAIL score_serving: got %b, required 1", serving);
        else passed = passed + 1;
        for (int i = 0; i < 3; i++) begin
            tick(0);
            idle(7);
        end
        total = total + 1;
        if (serving !== 1'b0) $display("FAIL serve_done: got serving=%b, required 0", serving);
        else passed = passed + 1;
        tick(0);
        idle(7);
        tick(4);
        idle(7);
        check_drained("score");
    endtask

    task automatic test_over();
        tick(0);
        idle(7);
        tick(4);
        idle(1);
        game_over = 1'b1;
        ai_scored = 1'b1;
        idle(1);
        game_over = 1'b0;
        ai_scored = 1'b0;
        idle(6);
        total = total + 1;
        if ({halted, serving} !== 2'b10)
            $display("FAIL over_wins: got halted,serving=%b, required 10", {halted, serving});
        else
            passed = passed + 1;
        for (int i = 0; i < 10; i++) begin
            tick(0);
            idle(3);
        end
        total = total + 1;
        if (halted !== 1'b1) $display("FAIL over_holds: got halted=%b, required 1", halted);
        else passed = passed + 1;
        press();
        total = total + 1;
        if (halted !== 1'b0) $display("FAIL over_restart: got halted=%b, required 0", halted);
        else passed = passed + 1;
        tick(0);
        idle(7);
        tick(4);
        check_drained("over");
    endtask

    task automatic test_pause();
        tick(0);
        idle(7);
        tick(4);
        press();
        total = total + 1;
        if (paused !== 1'b1) $display("FAIL pause_enter: got paused=%b, required 1", paused);
        else passed = passed + 1;
        tick(0);
        idle(5);
        tick(0);
        idle(5);
        press();
        total = total + 1;
        if (paused !== 1'b0) $display("FAIL pause_exit: got paused=%b, required 0", paused);
        else passed = passed + 1;
        tick(0);
        idle(7);
        tick(4);
        check_drained("pause");
    endtask

    task automatic test_overrun();
        tick(0);
        idle(7);
        tick(4);
        idle(2);
        tick(0);
        idle(6);
        total = total + 1;
        if (frame_overrun !== 1'b1) $display("FAIL overrun_set: got %b, required 1", frame_overrun);
        else passed = passed + 1;
        tick(0);
        idle(7);
        tick(4);
        check_drained("overrun");
        total = total + 1;
        if (frame_overrun !== 1'b1) $display("FAIL overrun_sticky: got %b, required 1", frame_overrun);
        else passed = passed + 1;
    endtask

    task automatic test_reset_mid_burst();
        tick(0);
        idle(7);
        exp_q.push_back('{start: cyc + 1, len: 1});
        frame_tick = 1'b1;
        idle(1);
        frame_tick = 1'b0;
        idle(1);
        reset = 1'b1;
        #1;
        total = total + 1;
        if ({step_en, paused, serving, halted, frame_overrun} !== 5'b0)
            $display("FAIL reset_mid_burst: got %b, required 00000",
                     {step_en, paused, serving, halted, frame_overrun});
        else
            passed = passed + 1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(6);
        total = total + 1;
        if ({step_en, paused, serving, halted, frame_overrun} !== 5'b0)
            $display("FAIL reset_no_resume: got %b, required 00000",
                     {step_en, paused, serving, halted, frame_overrun});
        else
            passed = passed + 1;
        tick(0);
        idle(7);
        tick(4);
        check_drained("reset_mid");
    endtask

    task automatic test_back_to_back();
        // Ticks every 6 clocks: bursts land right after every second tick.
        for (int i = 0; i < 6; i++) begin
            tick((i % 2 == 1) ? 4 : 0);
            idle(5);
        end
        check_drained("back_to_back");
    endtask

`ifdef SCHED_DEBOUNCE_EN
    task automatic test_debounce_glitch();
        btn_raw = 1'b1;
        idle(5);
        btn_raw = 1'b0;
        idle(20);
        total = total + 1;
        if (paused !== 1'b0) $display("FAIL debounce_glitch: got paused=%b, required 0", paused);
        else passed = passed + 1;
    endtask
`endif

    initial begin
        reset = 1'b1;
        frame_tick = 1'b0;
        btn_raw = 1'b0;
        player_scored = 1'b0;
        ai_scored = 1'b0;
        game_over = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_bursts();
        test_score();
        test_over();
        test_pause();
        test_overrun();
        test_reset_mid_burst();
        test_back_to_back();
`ifdef SCHED_DEBOUNCE_EN
        test_debounce_glitch();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
